// File: rtl/text_display_ctrl.sv
// Text-mode display controller: 640x400@70 timing, scrolled cell fetch, cursor and CGA palette.
// Define TEXT_BLINK_EN to use attr[7] as blink; otherwise attr[7:4] selects one of 16 backgrounds.
module text_display_ctrl #(
  parameter int COLS        = 80,
  parameter int ROWS        = 25,
  parameter int FONT_H      = 16,
  parameter int ADDR_W      = 13,
  parameter int FONT_BASE   = 4096,
  parameter int BLINK_TICKS = 12500000
) (
  input  logic              clock_25,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        data,
  input  logic [10:0]       start_cell,
  input  logic [10:0]       cursor,
  input  logic              cursor_en,
  input  logic [4:0]        cursor_shape_lo,
  input  logic [4:0]        cursor_shape_hi,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic              HS,
  output logic              VS,
  output logic              frame
);

  localparam int CELLS    = COLS * ROWS;
  localparam int TEXT_W   = COLS * 8;
  localparam int TEXT_H   = ROWS * FONT_H;
  localparam int FH_SHIFT = (FONT_H == 16) ? 4 : 3;
  localparam int TIMER_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [3:0] GL_MASK = 4'(FONT_H - 1);

  logic [9:0]         x_reg, x_next;
  logic [8:0]         y_reg, y_next;
  logic [10:0]        start_latch_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               flash_reg;
  logic               frame_reg;
  logic [11:0]        rgb_reg, rgb_next;
  logic [ADDR_W-1:0]  address_reg;
  logic [10:0]        fetch_cell_reg, disp_cell_reg;
  logic [7:0]         attr_reg, glyph_reg, disp_attr_reg, disp_glyph_reg;

  logic [9:0]  px, fx;
  logic [8:0]  ln, row;
  logic [3:0]  gline;
  logic [2:0]  phase;
  logic [6:0]  fcol;
  logic        in_vline, in_text, fetch_active, pix_bit, cursor_hit, pix_on;
  logic [11:0] cell_sum;
  logic [10:0] cell_fetch;
  logic [ADDR_W-1:0] font_addr;
  logic [3:0]  fg_idx, bg_idx;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 12'h000;
      4'h1: palette = 12'h00A;
      4'h2: palette = 12'h0A0;
      4'h3: palette = 12'h0AA;
      4'h4: palette = 12'hA00;
      4'h5: palette = 12'hA0A;
      4'h6: palette = 12'hA50;
      4'h7: palette = 12'hAAA;
      4'h8: palette = 12'h555;
      4'h9: palette = 12'h55F;
      4'hA: palette = 12'h5F5;
      4'hB: palette = 12'h5FF;
      4'hC: palette = 12'hF55;
      4'hD: palette = 12'hF5F;
      4'hE: palette = 12'hFF5;
      default: palette = 12'hFFF;
    endcase
  endfunction

  assign px       = x_reg - 10'd48;
  assign ln       = y_reg - 9'd35;
  // Fetch position runs one clock ahead of the prefetch column so the registered
  // address is already on the bus during the cell's phase 0.
  assign fx       = x_reg - 10'd39;
  assign phase    = fx[2:0];
  assign fcol     = fx[9:3];
  assign row      = ln >> FH_SHIFT;
  assign gline    = ln[3:0] & GL_MASK;
  assign in_vline = (y_reg >= 9'd35) && (ln < 9'(TEXT_H));
  assign in_text  = (x_reg >= 10'd48) && (px < 10'(TEXT_W)) && in_vline;
  assign fetch_active = in_vline && (fcol < 7'(COLS));

  assign cell_sum   = 12'(start_latch_reg) + 12'(row * COLS) + 12'(fcol);
  assign cell_fetch = (cell_sum >= 12'(CELLS)) ? 11'(cell_sum - 12'(CELLS)) : cell_sum[10:0];
  assign font_addr  = ADDR_W'(FONT_BASE + int'(data) * FONT_H + int'(gline));

  assign x_next = (x_reg == 10'd799) ? 10'd0 : x_reg + 10'd1;
  assign y_next = (x_reg != 10'd799) ? y_reg : ((y_reg == 9'd448) ? 9'd0 : y_reg + 9'd1);

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      x_reg           <= 10'd0;
      y_reg           <= 9'd0;
      start_latch_reg <= 11'd0;
      frame_reg       <= 1'b0;
      timer_reg       <= '0;
      flash_reg       <= 1'b0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      frame_reg <= (x_reg == 10'd0) && (y_reg == 9'd435);
      if ((x_reg == 10'd0) && (y_reg == 9'd0))
        start_latch_reg <= start_cell;
      if (timer_reg == TIMER_W'(BLINK_TICKS - 1)) begin
        timer_reg <= '0;
        flash_reg <= ~flash_reg;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      address_reg    <= '0;
      fetch_cell_reg <= 11'd0;
      disp_cell_reg  <= 11'd0;
      attr_reg       <= 8'd0;
      glyph_reg      <= 8'd0;
      disp_attr_reg  <= 8'd0;
      disp_glyph_reg <= 8'd0;
    end else begin
      case (phase)
        3'd0: begin
          // Hand the previous column to the display side while starting this one.
          disp_glyph_reg <= glyph_reg;
          disp_attr_reg  <= attr_reg;
          disp_cell_reg  <= fetch_cell_reg;
          fetch_cell_reg <= cell_fetch;
          if (fetch_active) address_reg <= ADDR_W'({cell_fetch, 1'b0});
        end
        3'd1: if (fetch_active) address_reg <= ADDR_W'({fetch_cell_reg, 1'b1});
        3'd2: if (fetch_active) address_reg <= font_addr;
        3'd3: attr_reg  <= data;
        3'd4: glyph_reg <= data;
        default: ;
      endcase
    end
  end

`ifdef TEXT_BLINK_EN
  assign bg_idx = {1'b0, disp_attr_reg[6:4]};
  assign fg_idx = (disp_attr_reg[7] && flash_reg) ? bg_idx : disp_attr_reg[3:0];
`else
  assign bg_idx = disp_attr_reg[7:4];
  assign fg_idx = disp_attr_reg[3:0];
`endif

  assign pix_bit    = disp_glyph_reg[~px[2:0]];
  assign cursor_hit = cursor_en && flash_reg && (disp_cell_reg == cursor) &&
                      ({1'b0, gline} >= cursor_shape_lo) && ({1'b0, gline} <= cursor_shape_hi);
  assign pix_on     = pix_bit || cursor_hit;
  assign rgb_next   = in_text ? palette(pix_on ? fg_idx : bg_idx) : 12'h000;

  always_ff @(posedge clock_25) begin
    if (!reset_n) rgb_reg <= 12'h000;
    else          rgb_reg <= rgb_next;
  end

  assign address = address_reg;
  assign R       = rgb_reg[11:8];
  assign G       = rgb_reg[7:4];
  assign B       = rgb_reg[3:0];
  assign HS      = !(x_reg >= 10'd704);
  assign VS      = (y_reg >= 9'd447);
  assign frame   = frame_reg;

endmodule
